accum_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one `top`-style accumulator datapath among `NREQ` requesters. Requesters present a 32-bit increment and hold `req` until acknowledged. The scheduler grants one requester at a time, drives the accumulator's `enable`/`value` pair with the spacing that datapath's 3-state sequencer needs, and returns a one-cycle `ack` when the add has committed. It sits between the requesting agents and the accumulator instance.

---
 rtl/accum_rr_scheduler.sv | 123 ++++++++++++
 tb/tb_accum_rr_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_rr_scheduler.sv
// rtl/accum_rr_scheduler.sv - round-robin scheduler sharing one accumulator among NREQ requesters
// Grants one request at a time, issues a single enable pulse, waits ACC_LAT cycles, then acks.
module accum_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int ACC_LAT = 3,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW     = $clog2(ACC_LAT + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_value,
  input  logic                    pause,
  output logic [NREQ-1:0]         ack,
  output logic                    acc_enable,
  output logic [WIDTH-1:0]        acc_value,
  output logic                    busy,
  output logic [IDW-1:0]          grant_id,
  output logic [15:0]             txn_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [WIDTH-1:0] acc_value_q, acc_value_d;
  logic [15:0]      txn_count_q, txn_count_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             acc_enable_q, acc_enable_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   idx;

  // First asserted request at or above ptr, wrapping around
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    acc_value_d = acc_value_q;
    txn_count_d = txn_count_q;
    ack_d       = '0;
    case (state_q)
      S_IDLE: begin
        if (!pause && found) begin
          state_d     = S_ISSUE;
          grant_id_d  = pick;
          acc_value_d = req_value[int'(pick)*WIDTH +: WIDTH];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CW'(ACC_LAT);
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_ACK;
          ack_d   = NREQ'(1) << grant_id_q;
        end
      end
      S_ACK: begin
        state_d     = S_IDLE;
        ptr_d       = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);
        txn_count_d = txn_count_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // Registered flags are derived from the state being entered
    acc_enable_d = (state_d == S_ISSUE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      grant_id_q   <= '0;
      acc_value_q  <= '0;
      txn_count_q  <= '0;
      ack_q        <= '0;
      acc_enable_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      grant_id_q   <= grant_id_d;
      acc_value_q  <= acc_value_d;
      txn_count_q  <= txn_count_d;
      ack_q        <= ack_d;
      acc_enable_q <= acc_enable_d;
      busy_q       <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign acc_enable = acc_enable_q;
  assign acc_value  = acc_value_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;
  assign txn_count  = txn_count_q;

endmodule

// File: tb/tb_accum_rr_scheduler.sv
// tb/tb_accum_rr_scheduler.sv - self-checking bench for accum_rr_scheduler
// Timeline model of each transaction plus directed scenarios and a random phase.
module tb_accum_rr_scheduler;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 32;
  localparam int ACC_LAT = 3;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b0;
  logic                  pause = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_value = '0;
  logic [NREQ-1:0]       ack;
  logic                  acc_enable;
  logic [WIDTH-1:0]      acc_value;
  logic                  busy;
  logic [1:0]            grant_id;
  logic [15:0]           txn_count;

  accum_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .ACC_LAT(ACC_LAT)) dut (
    .CLK(CLK), .RST(RST), .req(req), .req_value(req_value), .pause(pause),
    .ack(ack), .acc_enable(acc_enable), .acc_value(acc_value), .busy(busy),
    .grant_id(grant_id), .txn_count(txn_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model: t counts edges since the grant edge (-1 when no transaction is open)
  int               t = -1;
  int               m_ptr = 0;
  int               m_grant = 0;
  logic [WIDTH-1:0] m_value = '0;
  logic [15:0]      m_count = '0;
  int               cyc = 0;

  always @(posedge CLK) begin
    cyc++;
    if (!RST) begin
      t = -1; m_ptr = 0; m_grant = 0; m_value = '0; m_count = '0;
    end else if (t < 0) begin
      if (!pause && req != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (req[(m_ptr + k) % NREQ]) begin
            m_grant = (m_ptr + k) % NREQ;
            break;
          end
        end
        m_value = req_value[m_grant*WIDTH +: WIDTH];
        t = 0;
      end
    end else begin
      t++;
      if (t == ACC_LAT + 2) begin
        m_ptr = (m_grant + 1) % NREQ;
        m_count = m_count + 16'd1;
        t = -1;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("acc_enable", 64'(acc_enable), 64'(t == 0));
      chk("ack", 64'(ack), (t == ACC_LAT + 1) ? (64'd1 << m_grant) : 64'd0);
      chk("busy", 64'(busy), 64'(t >= 0));
      chk("grant_id", 64'(grant_id), 64'(m_grant));
      chk("acc_value", 64'(acc_value), 64'(m_value));
      chk("txn_count", 64'(txn_count), 64'(m_count));
    end
  end

  // Observers: enable/ack history and an accumulator adding two edges after it samples enable
  int          n_en = 0;
  int          n_ack = 0;
  int          en_cycs[$];
  int          ack_ids[$];
  int          pend = 0;
  logic [31:0] sum = '0;

  always @(negedge CLK) begin
    if (pend > 0) begin
      pend--;
      if (pend == 0) sum = sum + acc_value;
    end
    if (acc_enable) begin
      n_en++;
      en_cycs.push_back(cyc);
      pend = 2;
    end
    for (int k = 0; k < NREQ; k++) begin
      if (ack[k]) begin
        n_ack++;
        ack_ids.push_back(k);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_for(input bit want_ack, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if ((!want_ack && acc_enable) || (want_ack && ack != '0)) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout waiting for %s: got none expected event within %0d cycles",
               want_ack ? "ack" : "acc_enable", limit);
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  int          e0, en_c, ack_c, n0;
  logic [31:0] s0;

  initial begin
    // Reset state
    RST = 1'b0;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_txn_count", 64'(txn_count), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    RST = 1'b1;

    // Single request
    req_value[0*WIDTH +: WIDTH] = 32'd5;
    req = 4'b0001;
    @(posedge CLK);
    #1 e0 = cyc;
    wait_for(1'b0, 10);
    en_c = cyc;
    wait_for(1'b1, 10);
    ack_c = cyc;
    req = '0;
    chk("single_ack_val", 64'(ack), 64'h1);
    chk("single_en_lat", 64'(en_c - e0), 64'd0);
    chk("single_ack_lat", 64'(ack_c - e0), 64'd4);
    tick(2);
    chk("single_txn_count", 64'(txn_count), 64'd1);
    chk("single_sum", 64'(sum), 64'd5);
    chk("single_en_pulses", 64'(n_en), 64'd1);

    // Fairness with all four requesting
    pulse_reset();
    sum = '0;
    en_cycs.delete();
    ack_ids.delete();
    for (int i = 0; i < NREQ; i++) req_value[i*WIDTH +: WIDTH] = 32'(i + 1);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) wait_for(1'b1, 12);
    req = '0;
    tick(3);
    chk("rr_count", 64'(ack_ids.size()), 64'd8);
    for (int i = 0; i < 8 && i < ack_ids.size(); i++) chk("rr_order", 64'(ack_ids[i]), 64'(i % 4));
    chk("rr_sum", 64'(sum), 64'd20);
    for (int i = 1; i < en_cycs.size(); i++) chk("rr_en_gap", 64'(en_cycs[i] - en_cycs[i-1]), 64'd6);

    // Value stability while granted
    s0 = sum;
    req_value[0*WIDTH +: WIDTH] = 32'd7;
    req = 4'b0001;
    wait_for(1'b0, 10);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      req_value[0*WIDTH +: WIDTH] = $urandom;
      chk("hold_acc_value", 64'(acc_value), 64'd7);
      if (ack != '0) break;
    end
    req = '0;
    tick(2);
    chk("hold_sum", 64'(sum), 64'(s0 + 32'd7));

    // Pause after a grant
    pulse_reset();
    req_value[0*WIDTH +: WIDTH] = 32'd10;
    req_value[1*WIDTH +: WIDTH] = 32'd20;
    req = 4'b0011;
    wait_for(1'b0, 10);
    chk("pause_first_grant", 64'(grant_id), 64'd0);
    pause = 1'b1;
    wait_for(1'b1, 10);
    chk("pause_ack", 64'(ack), 64'h1);
    req = 4'b0010;
    n0 = n_en;
    tick(10);
    chk("pause_no_enable", 64'(n_en), 64'(n0));
    chk("pause_idle", 64'(busy), 64'd0);
    pause = 1'b0;
    @(negedge CLK);
    chk("unpause_enable", 64'(acc_enable), 64'd1);
    chk("unpause_grant", 64'(grant_id), 64'd1);
    wait_for(1'b1, 10);
    req = '0;
    tick(1);

    // Early drop, then reset in the middle of a transaction
    req_value[2*WIDTH +: WIDTH] = 32'd9;
    req = 4'b0100;
    wait_for(1'b0, 10);
    req = '0;
    wait_for(1'b1, 10);
    chk("drop_ack", 64'(ack), 64'h4);
    tick(1);
    req_value[3*WIDTH +: WIDTH] = 32'd11;
    req = 4'b1000;
    wait_for(1'b0, 10);
    tick(2);
    RST = 1'b0;
    req = 4'b1001;
    n0 = n_ack;
    @(negedge CLK);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_en", 64'(acc_enable), 64'd0);
    chk("mid_rst_ack", 64'(ack), 64'd0);
    chk("mid_rst_txn", 64'(txn_count), 64'd0);
    chk("mid_rst_gid", 64'(grant_id), 64'd0);
    chk("mid_rst_val", 64'(acc_value), 64'd0);
    RST = 1'b1;
    wait_for(1'b0, 10);
    chk("post_rst_grant", 64'(grant_id), 64'd0);
    chk("post_rst_no_ack", 64'(n_ack), 64'(n0));
    req = '0;
    wait_for(1'b1, 10);
    tick(2);

    // Transaction counter wrap
    chk_en = 1'b0;
    @(negedge CLK);
    force dut.txn_count_q = 16'hFFFE;
    m_count = 16'hFFFE;
    #1 release dut.txn_count_q;
    chk_en = 1'b1;
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      wait_for(1'b1, 12);
      @(negedge CLK);
      chk("wrap_txn_count", 64'(txn_count), 64'(16'(32'hFFFF + i)));
    end
    req = '0;
    tick(3);
    chk("wrap_grant", 64'(grant_id), 64'd0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      RST = ($urandom_range(0, 199) != 0);
      req = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) req_value[k*WIDTH +: WIDTH] = $urandom;
      pause = ($urandom_range(0, 9) == 0);
    end
    RST = 1'b1;
    req = '0;
    pause = 1'b0;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
